// File: rtl/product_divider.sv
// -----------------------------------------------------------------------------
// product_divider
//   Reads an 8-bit product back from the product RAM and divides it by a 4-bit
//   divisor with a sequential restoring divider (one quotient bit per cycle,
//   MSB first). Returns quotient and remainder so stored products can be
//   checked against their operands or factored back to recover an operand.
//   Shares the RAM read port with the multiplier; the top level arbitrates.
//
// Ports
//   clk_i          system clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset, aborts any operation
//   start_i        request, only honoured in IDLE
//   rd_adr_i       RAM address of the dividend, latched on accepted start
//   divisor_i      divisor, latched on accepted start
//   ram_adr_o      address to the RAM read port (held from start to next start)
//   ram_rd_data_i  RAM read data (combinational or 1-cycle registered RAM)
//   busy_o         high in every non-IDLE state
//   done_o         one-cycle completion pulse
//   quotient_o     quotient, held until the next completion
//   remainder_o    remainder, held until the next completion
//   div_by_zero_o  set with done when the divisor was 0, held with results
//
// States
//   S_IDLE | waiting for start; latches address and divisor
//   S_ADDR | address on the RAM port, read in flight
//   S_LOAD | capture dividend, clear working registers, catch divide-by-zero
//   S_DIV  | one restoring-division iteration per cycle, DATA_W cycles
//   S_DONE | done pulse, results valid
// -----------------------------------------------------------------------------
module product_divider #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] rd_adr_i,
    input  logic [DIV_W-1:0]  divisor_i,
    output logic [ADDR_W-1:0] ram_adr_o,
    input  logic [DATA_W-1:0] ram_rd_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DIV_W-1:0]  remainder_o,
    output logic              div_by_zero_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  adr_q;
    logic [DIV_W-1:0]   div_q;
    logic [DATA_W-1:0]  dvd_q;
    logic [DATA_W-1:0]  quo_q;
    // Between iterations the remainder is always below the divisor, so only
    // DIV_W bits are stored; the extra bit exists only in the shifted value.
    logic [DIV_W-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [DATA_W-1:0]  quotient_q;
    logic [DIV_W-1:0]   remainder_q;
    logic               dbz_q;

    logic [DIV_W:0]     rem_shift;
    logic               q_bit;
    logic [DIV_W-1:0]   rem_d;
    logic [DATA_W-1:0]  quo_d;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, dvd_q[DATA_W-1]};
        q_bit     = (rem_shift >= {1'b0, div_q});
        rem_d     = q_bit ? DIV_W'(rem_shift - {1'b0, div_q})
                          : rem_shift[DIV_W-1:0];
        quo_d     = {quo_q[DATA_W-2:0], q_bit};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            div_q       <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        adr_q   <= rd_adr_i;
                        div_q   <= divisor_i;
                        busy_q  <= 1'b1;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    dvd_q <= ram_rd_data_i;
                    rem_q <= '0;
                    quo_q <= '0;
                    cnt_q <= '0;
                    if (div_q == '0) begin
                        quotient_q  <= '1;
                        remainder_q <= '0;
                        dbz_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_adr_o     = adr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_product_divider.sv
// -----------------------------------------------------------------------------
// tb_product_divider
//   Self-checking bench for product_divider. A small RAM model with a 1-cycle
//   registered read port feeds the DUT. Each accepted start pushes the result
//   computed with the native / and % operators onto a scoreboard queue; the
//   entry is popped and compared when done is observed.
// -----------------------------------------------------------------------------
module tb_product_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] rd_adr;
    logic [3:0] divisor;
    logic [2:0] ram_adr;
    logic [7:0] ram_rd_data;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dbz;

    logic [7:0] ram [8];

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    product_divider dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .rd_adr_i      (rd_adr),
        .divisor_i     (divisor),
        .ram_adr_o     (ram_adr),
        .ram_rd_data_i (ram_rd_data),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_rd_data <= ram[ram_adr];

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Drives start for one cycle; call right after a negedge with the DUT idle.
    // Returns one negedge after the accepting edge (cycle 1).
    task automatic issue(input logic [2:0] adr, input logic [3:0] dv);
        exp_t e;
        logic [7:0] d;
        d = ram[adr];
        if (dv == 4'd0) begin
            e.q = 8'hFF;
            e.r = 4'd0;
            e.z = 1'b1;
        end else begin
            e.q = 8'(d / {4'd0, dv});
            e.r = 4'(d % {4'd0, dv});
            e.z = 1'b0;
        end
        sb.push_back(e);
        rd_adr  = adr;
        divisor = dv;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Steps negedges until done is seen (bounded). cyc is the cycle number
    // in which done was observed, counting from c0 at entry.
    task automatic wait_done(input int c0, output int cyc,
                             output bit busy_ok, output bit held_ok);
        logic [7:0] q0;
        logic [3:0] r0;
        logic       z0;
        q0 = quotient;
        r0 = remainder;
        z0 = dbz;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        cyc = c0;
        while (done !== 1'b1 && cyc < c0 + 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (quotient !== q0 || remainder !== r0 || dbz !== z0) held_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        rd_adr = 3'd0;
        divisor = 4'd0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, dbz, ram_adr, quotient, remainder} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b dbz=%b adr=%0d q=%0d r=%0d, required all 0",
                     busy, done, dbz, ram_adr, quotient, remainder);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        bit bok, hok;
        exp_t e;
        issue(3'd3, 4'd5);
        wait_done(1, cyc, bok, hok);
        n_tests++;
        if (done !== 1'b1 || cyc !== 11) begin
            n_fail++;
            $display("FAIL basic_latency: done=%b at cycle %0d, required done=1 at cycle 11", done, cyc);
        end
        n_tests++;
        if (!bok) begin
            n_fail++;
            $display("FAIL basic_busy: busy low somewhere in cycles 1-%0d, required high", cyc);
        end
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z} || quotient !== 8'd9) begin
            n_fail++;
            $display("FAIL basic_result: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_hold();
        int cyc;
        bit bok, hok;
        exp_t e;
        issue(3'd7, 4'd7);
        wait_done(1, cyc, bok, hok);
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z} || quotient !== 8'd32) begin
            n_fail++;
            $display("FAIL hold_first: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
        issue(3'd0, 4'd3);
        wait_done(1, cyc, bok, hok);
        n_tests++;
        if (!hok) begin
            n_fail++;
            $display("FAIL hold_stable: results changed before done at cycle %0d, required held", cyc);
        end
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
            n_fail++;
            $display("FAIL hold_second: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_div1_15();
        int cyc;
        bit bok, hok;
        exp_t e;
        issue(3'd2, 4'd1);
        wait_done(1, cyc, bok, hok);
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z} || quotient !== 8'd255) begin
            n_fail++;
            $display("FAIL div1: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
        issue(3'd2, 4'd15);
        wait_done(1, cyc, bok, hok);
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z} || quotient !== 8'd17) begin
            n_fail++;
            $display("FAIL div15: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int cyc;
        bit bok, hok;
        exp_t e;
        issue(3'd5, 4'd0);
        wait_done(1, cyc, bok, hok);
        n_tests++;
        if (done !== 1'b1 || cyc !== 3 || !bok) begin
            n_fail++;
            $display("FAIL dbz_latency: done=%b at cycle %0d busy_ok=%b, required done=1 at cycle 3 busy_ok=1",
                     done, cyc, bok);
        end
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
            n_fail++;
            $display("FAIL dbz_result: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
        issue(3'd3, 4'd5);
        wait_done(1, cyc, bok, hok);
        n_tests++;
        if (!hok) begin
            n_fail++;
            $display("FAIL dbz_held: div_by_zero result not held while busy");
        end
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
            n_fail++;
            $display("FAIL dbz_clear: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int cyc;
        int dc0;
        bit bok, hok;
        exp_t e;
        dc0 = done_cnt;
        issue(3'd7, 4'd5);
        repeat (4) @(negedge clk);
        // cycle 5: DIV in progress; stray request with different operands
        start   = 1'b1;
        rd_adr  = 3'd2;
        divisor = 4'd1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(6, cyc, bok, hok);
        n_tests++;
        if (done !== 1'b1 || cyc !== 11) begin
            n_fail++;
            $display("FAIL ignore_latency: done=%b at cycle %0d, required done=1 at cycle 11", done, cyc);
        end
        e = sb.pop_front();
        n_tests++;
        if ({quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
            n_fail++;
            $display("FAIL ignore_result: q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                     quotient, remainder, dbz, e.q, e.r, e.z);
        end
        repeat (15) @(negedge clk);
        n_tests++;
        if (done_cnt - dc0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_single_done: %0d done pulses busy=%b, required 1 pulse busy=0",
                     done_cnt - dc0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int dc0;
        bit bok, hok;
        exp_t e;
        issue(3'd7, 4'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        n_tests++;
        if ({busy, done, dbz, ram_adr, quotient, remainder} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b dbz=%b adr=%0d q=%0d r=%0d, required all 0",
                     busy, done, dbz, ram_adr, quotient, remainder);
        end
        dc0 = done_cnt;
        repeat (20) @(negedge clk);
        n_tests++;
        if (done_cnt !== dc0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: %0d done pulses busy=%b, required 0 pulses busy=0",
                     done_cnt - dc0, busy);
        end
        issue(3'd3, 4'd5);
        wait_done(1, cyc, bok, hok);
        e = sb.pop_front();
        n_tests++;
        if (done !== 1'b1 || cyc !== 11 || {quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: done=%b cycle=%0d q=%0d r=%0d z=%b, required done=1 cycle=11 q=%0d r=%0d z=%b",
                     done, cyc, quotient, remainder, dbz, e.q, e.r, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit bok, hok;
        exp_t e;
        logic [2:0] a;
        logic [3:0] dv;
        for (int i = 0; i < 10; i++) begin
            a  = 3'($urandom_range(0, 7));
            dv = 4'($urandom_range(0, 15));
            if (i == 0) dv = 4'd0;
            issue(a, dv);
            wait_done(1, cyc, bok, hok);
            e = sb.pop_front();
            n_tests++;
            if (done !== 1'b1 || cyc !== ((dv == 4'd0) ? 3 : 11) ||
                {quotient, remainder, dbz} !== {e.q, e.r, e.z}) begin
                n_fail++;
                $display("FAIL b2b_%0d: adr=%0d div=%0d cycle=%0d q=%0d r=%0d z=%b, required q=%0d r=%0d z=%b",
                         i, a, dv, cyc, quotient, remainder, dbz, e.q, e.r, e.z);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0] = 8'd0;
        ram[2] = 8'd255;
        ram[3] = 8'd45;
        ram[5] = 8'd12;
        ram[7] = 8'd225;
        rst = 1'b1;
        start = 1'b0;
        rd_adr = 3'd0;
        divisor = 4'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_div1_15();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
